cm0_dap_cdc_recv_addr: RTL and testbench

Receive-side partner of the DAP 4-bit CDC send register. Synchronises a toggle request from the launching domain, captures the 4-bit address the launch register holds stable, and presents it to the local consumer with a valid/ready handshake. The acknowledge toggle returned to the launching domain lets the sender reload its register only after the capture is complete.

---
 rtl/cm0_dap_cdc_pkg.sv | 17 +
 rtl/cm0_dap_cdc_recv_addr_if.sv | 23 ++
 rtl/cm0_dap_cdc_sync.sv | 24 ++
 rtl/cm0_dap_cdc_recv_addr.sv | 110 +++++++++++
 tb/tb_cm0_dap_cdc_recv_addr.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/cm0_dap_cdc_pkg.sv
// Shared types and constants for the DAP 4-bit CDC address receive path.
package cm0_dap_cdc_pkg;

  localparam int ADDR_W          = 4;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic bit sync_stages_ok(input int n);
    return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
  endfunction

endpackage

// File: rtl/cm0_dap_cdc_recv_addr_if.sv
// Request/address/handshake bundle between the launching domain, the receiver and its consumer.
interface cm0_dap_cdc_recv_addr_if;
  import cm0_dap_cdc_pkg::*;

  logic              REQ;
  logic [ADDR_W-1:0] ADDRI;
  logic              ADDRREADY;
  logic              ADDRVALID;
  logic [ADDR_W-1:0] ADDRO;
  logic              ACK;
  logic              OVERRUN;

  modport master (
    output REQ, ADDRI, ADDRREADY,
    input  ADDRVALID, ADDRO, ACK, OVERRUN
  );

  modport slave (
    input  REQ, ADDRI, ADDRREADY,
    output ADDRVALID, ADDRO, ACK, OVERRUN
  );

endinterface

// File: rtl/cm0_dap_cdc_sync.sv
// N-stage single-bit synchroniser, kept as its own cell so it can be mapped to
// dedicated synchroniser flops and constrained by name.
module cm0_dap_cdc_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] stage_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[N-2:0], d};
    end
  end

  assign q = stage_q[N-1];

endmodule

// File: rtl/cm0_dap_cdc_recv_addr.sv
// Receive side of the DAP 4-bit CDC register: synchronises the REQ toggle, captures
// the launched address, offers it with valid/ready and returns an ACK toggle.
module cm0_dap_cdc_recv_addr
  import cm0_dap_cdc_pkg::*;
#(
  parameter int PRESENT     = 1,
  parameter int SYNC_STAGES = 2
) (
  input logic                     REGCLK,
  input logic                     RARREGRESET,
  cm0_dap_cdc_recv_addr_if.slave  bus
);

  if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync_stages
    $error("cm0_dap_cdc_recv_addr: SYNC_STAGES must be in 2..4");
  end

  if (PRESENT != 0) begin : g_present

    logic              req_s;
    logic              req_seen_q;
    logic              new_req;
    logic              capture;
    logic              handshake;
    logic              overrun_set;
    state_e            state_q;
    state_e            state_d;
    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic              ack_q;
    logic              overrun_q;

    cm0_dap_cdc_sync #(
      .N   (SYNC_STAGES)
    ) u_req_sync (
      .clk (REGCLK),
      .rst (RARREGRESET),
      .d   (bus.REQ),
      .q   (req_s)
    );

    // A request arriving while an address is held is flagged, not captured;
    // it stays pending (req_seen untouched) and is taken once back in IDLE.
    always_comb begin
      state_d     = state_q;
      capture     = 1'b0;
      handshake   = 1'b0;
      overrun_set = 1'b0;
      new_req     = (req_s != req_seen_q);
      unique case (state_q)
        IDLE: begin
          if (new_req) begin
            capture = 1'b1;
            state_d = HOLD;
          end
        end
        HOLD: begin
          overrun_set = new_req;
          if (bus.ADDRREADY) begin
            handshake = 1'b1;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // ADDRVALID is its own flop so the consumer sees no decode of the state.
    always_ff @(posedge REGCLK) begin
      if (RARREGRESET) begin
        state_q    <= IDLE;
        valid_q    <= 1'b0;
        addr_q     <= '0;
        req_seen_q <= 1'b0;
        ack_q      <= 1'b0;
        overrun_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        valid_q <= (state_d == HOLD);
        if (capture) begin
          addr_q     <= bus.ADDRI;
          req_seen_q <= req_s;
        end
        if (handshake) begin
          ack_q <= ~ack_q;
        end
        if (overrun_set) begin
          overrun_q <= 1'b1;
        end
      end
    end

    assign bus.ADDRVALID = valid_q;
    assign bus.ADDRO     = addr_q;
    assign bus.ACK       = ack_q;
    assign bus.OVERRUN   = overrun_q;

  end else begin : g_absent

    logic unused_inputs;
    assign unused_inputs = ^{REGCLK, RARREGRESET, bus.REQ, bus.ADDRI, bus.ADDRREADY};

    assign bus.ADDRVALID = 1'b0;
    assign bus.ADDRO     = '0;
    assign bus.ACK       = 1'b0;
    assign bus.OVERRUN   = 1'b0;

  end

endmodule

// File: tb/tb_cm0_dap_cdc_recv_addr.sv
// Scoreboard bench for cm0_dap_cdc_recv_addr: directed transfers, overrun, reset-in-HOLD
// and a PRESENT=0 instance that must stay silent.
module tb_cm0_dap_cdc_recv_addr;
  import cm0_dap_cdc_pkg::*;

  localparam int SYNC = 2;

  logic REGCLK;
  logic RARREGRESET;

  int checks   = 0;
  int failures = 0;
  int received = 0;

  logic [ADDR_W-1:0] expQ[$];

  cm0_dap_cdc_recv_addr_if bus();
  cm0_dap_cdc_recv_addr_if busNp();

  cm0_dap_cdc_recv_addr #(.PRESENT(1), .SYNC_STAGES(SYNC)) dut (
    .REGCLK      (REGCLK),
    .RARREGRESET (RARREGRESET),
    .bus         (bus.slave)
  );

  cm0_dap_cdc_recv_addr #(.PRESENT(0), .SYNC_STAGES(SYNC)) dutNp (
    .REGCLK      (REGCLK),
    .RARREGRESET (RARREGRESET),
    .bus         (busNp.slave)
  );

  initial REGCLK = 1'b0;
  always #5 REGCLK = ~REGCLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: wake up just after the active edge so checks and drives are clear of it.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge REGCLK);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [ADDR_W-1:0] addr, input logic ready);
    bus.REQ       = req;
    bus.ADDRI     = addr;
    bus.ADDRREADY = ready;
  endtask

  // Sender side: toggle REQ with a new address, then wait for the ACK to change.
  task automatic sendAddr(input logic [ADDR_W-1:0] addr);
    logic prevAck;
    int   waited;
    prevAck = bus.ACK;
    expQ.push_back(addr);
    applyStimulus(~bus.REQ, addr, bus.ADDRREADY);
    waited = 0;
    while (bus.ACK == prevAck && waited < 20) begin
      tick(1);
      waited++;
    end
    checkOutput("ack_toggle_seen", {31'd0, bus.ACK != prevAck}, 32'd1);
  endtask

  // Monitor: the edge after this negedge completes a handshake when valid&ready.
  initial begin
    forever begin
      @(negedge REGCLK);
      if (!RARREGRESET && bus.ADDRVALID && bus.ADDRREADY) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_transfer", {28'd0, bus.ADDRO}, 32'hFFFF_FFFF);
        end else begin
          checkOutput("sb_addro", {28'd0, bus.ADDRO}, {28'd0, expQ.pop_front()});
          received++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [ADDR_W-1:0] rnd;

    RARREGRESET = 1'b1;
    applyStimulus(1'b0, 4'h0, 1'b0);
    busNp.REQ       = 1'b0;
    busNp.ADDRI     = 4'h0;
    busNp.ADDRREADY = 1'b1;
    tick(2);
    RARREGRESET = 1'b0;
    tick(1);
    checkOutput("rst_addrvalid", {31'd0, bus.ADDRVALID}, 32'd0);
    checkOutput("rst_addro",     {28'd0, bus.ADDRO},     32'd0);
    checkOutput("rst_ack",       {31'd0, bus.ACK},       32'd0);
    checkOutput("rst_overrun",   {31'd0, bus.OVERRUN},   32'd0);

    // Single transfer with ready held high: one-cycle HOLD.
    expQ.push_back(4'hA);
    applyStimulus(1'b1, 4'hA, 1'b1);
    tick(SYNC);
    checkOutput("t1_valid_early", {31'd0, bus.ADDRVALID}, 32'd0);
    tick(1);
    checkOutput("t1_valid",  {31'd0, bus.ADDRVALID}, 32'd1);
    checkOutput("t1_addro",  {28'd0, bus.ADDRO},     32'hA);
    checkOutput("t1_ack_pre",{31'd0, bus.ACK},       32'd0);
    tick(1);
    checkOutput("t1_valid_drop", {31'd0, bus.ADDRVALID}, 32'd0);
    checkOutput("t1_ack",        {31'd0, bus.ACK},       32'd1);
    checkOutput("t1_overrun",    {31'd0, bus.OVERRUN},   32'd0);

    // Stalled consumer: address held steady while ADDRI moves.
    expQ.push_back(4'h5);
    applyStimulus(1'b0, 4'h5, 1'b0);
    tick(SYNC + 1);
    applyStimulus(1'b0, 4'hF, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checkOutput("t2_valid_hold", {31'd0, bus.ADDRVALID}, 32'd1);
      checkOutput("t2_addro_hold", {28'd0, bus.ADDRO},     32'h5);
    end
    checkOutput("t2_ack_hold", {31'd0, bus.ACK}, 32'd1);
    applyStimulus(1'b0, 4'hF, 1'b1);
    tick(1);
    checkOutput("t2_valid_drop", {31'd0, bus.ADDRVALID}, 32'd0);
    checkOutput("t2_ack",        {31'd0, bus.ACK},       32'd0);
    tick(4);
    checkOutput("t2_no_recapture", {31'd0, bus.ADDRVALID}, 32'd0);
    checkOutput("t2_ack_once",     {31'd0, bus.ACK},       32'd0);

    // Four back-to-back transfers paced by ACK.
    for (int a = 1; a <= 4; a++) begin
      sendAddr(ADDR_W'(a));
    end
    tick(2);
    checkOutput("t3_ack_end",  {31'd0, bus.ACK},     32'd0);
    checkOutput("t3_received", received,             32'd6);
    checkOutput("t3_overrun",  {31'd0, bus.OVERRUN}, 32'd0);

    // Overrun: second toggle while the first address is held.
    expQ.push_back(4'h7);
    applyStimulus(~bus.REQ, 4'h7, 1'b0);
    tick(SYNC + 1);
    checkOutput("t4_addro_first", {28'd0, bus.ADDRO}, 32'h7);
    expQ.push_back(4'h9);
    applyStimulus(~bus.REQ, 4'h9, 1'b0);
    tick(SYNC + 1);
    checkOutput("t4_overrun",     {31'd0, bus.OVERRUN},   32'd1);
    checkOutput("t4_valid",       {31'd0, bus.ADDRVALID}, 32'd1);
    checkOutput("t4_addro_kept",  {28'd0, bus.ADDRO},     32'h7);
    applyStimulus(bus.REQ, 4'h9, 1'b1);
    tick(1);
    checkOutput("t4_idle_gap", {31'd0, bus.ADDRVALID}, 32'd0);
    checkOutput("t4_ack1",     {31'd0, bus.ACK},       32'd1);
    tick(1);
    checkOutput("t4_valid2", {31'd0, bus.ADDRVALID}, 32'd1);
    checkOutput("t4_addro2", {28'd0, bus.ADDRO},     32'h9);
    tick(1);
    checkOutput("t4_ack2",          {31'd0, bus.ACK},     32'd0);
    checkOutput("t4_overrun_stick", {31'd0, bus.OVERRUN}, 32'd1);

    // Reset while holding: address discarded, ACK/OVERRUN cleared, no recapture.
    sendAddr(4'h3);
    checkOutput("t5_ack_pre", {31'd0, bus.ACK}, 32'd1);
    applyStimulus(~bus.REQ, 4'hC, 1'b0);
    tick(SYNC + 1);
    checkOutput("t5_valid_pre",   {31'd0, bus.ADDRVALID}, 32'd1);
    checkOutput("t5_addro_pre",   {28'd0, bus.ADDRO},     32'hC);
    checkOutput("t5_overrun_pre", {31'd0, bus.OVERRUN},   32'd1);
    RARREGRESET = 1'b1;
    tick(1);
    RARREGRESET = 1'b0;
    checkOutput("t5_valid_rst",   {31'd0, bus.ADDRVALID}, 32'd0);
    checkOutput("t5_addro_rst",   {28'd0, bus.ADDRO},     32'd0);
    checkOutput("t5_ack_rst",     {31'd0, bus.ACK},       32'd0);
    checkOutput("t5_overrun_rst", {31'd0, bus.OVERRUN},   32'd0);
    tick(SYNC + 4);
    checkOutput("t5_no_spurious", {31'd0, bus.ADDRVALID}, 32'd0);

    // Absent instance stays silent whatever its inputs do.
    for (int i = 0; i < 8; i++) begin
      rnd = ADDR_W'($urandom_range(0, 15));
      busNp.ADDRI = rnd;
      busNp.REQ   = ~busNp.REQ;
      tick(SYNC + 2);
      checkOutput("np_outputs", {25'd0, busNp.ADDRVALID, busNp.ADDRO, busNp.ACK, busNp.OVERRUN}, 32'd0);
    end

    checkOutput("sb_drained", expQ.size(), 32'd0);
    checkOutput("sb_count",   received,    32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
